// File: rtl/l2_icache_resp_if.sv
// l2_icache_resp_if: icache line request/response bus plus the L2 memory port
interface l2_icache_resp_if;
  logic [2:0] icache_l2_op;
  logic [31:0] icache_l2_addr;
  logic [511:0] icache_l2_data_out;
  logic [2:0] icache_l2_state;
  logic l2_icache_stall;
  logic [2:0] l2_icache_op;
  logic [31:0] l2_icache_addr;
  logic [511:0] l2_icache_data;
  logic [2:0] l2_icache_state;
  logic mem_req_valid;
  logic mem_req_we;
  logic [31:0] mem_req_addr;
  logic [511:0] mem_req_data;
  logic mem_req_ready;
  logic mem_resp_valid;
  logic [511:0] mem_resp_data;
  logic err_illegal;
  modport slave (
    input icache_l2_op, icache_l2_addr, icache_l2_data_out, icache_l2_state,
    input mem_req_ready, mem_resp_valid, mem_resp_data,
    output l2_icache_stall, l2_icache_op, l2_icache_addr, l2_icache_data, l2_icache_state,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_data, err_illegal
  );
  modport master (
    output icache_l2_op, icache_l2_addr, icache_l2_data_out, icache_l2_state,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input l2_icache_stall, l2_icache_op, l2_icache_addr, l2_icache_data, l2_icache_state,
    input mem_req_valid, mem_req_we, mem_req_addr, mem_req_data, err_illegal
  );
endinterface

// File: rtl/l2_icache_resp.sv
// l2_icache_resp: queues icache line requests and services them in order against a memory port
module l2_icache_resp #(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  l2_icache_resp_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, RESP} st_t;
  st_t st;
  logic [2:0] f_op [FIFO_DEPTH];
  logic [25:0] f_line [FIFO_DEPTH];
  logic [511:0] f_data [FIFO_DEPTH];
  logic [2:0] f_state [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [2:0] w_op;
  logic [25:0] w_line;
  logic push, pop, unused;
  assign bus.l2_icache_stall = cnt == (AW+1)'(FIFO_DEPTH);
  assign push = bus.icache_l2_op != 3'd0 && bus.icache_l2_op < 3'd5 && !bus.l2_icache_stall;
  assign pop = st == IDLE && cnt != '0;
  assign unused = ^{bus.icache_l2_addr[5:0], f_state[rp]};
  // request payload storage, written at the tail on accept
  always_ff @(posedge clk)
    if (push) begin
      f_op[wp] <= bus.icache_l2_op;
      f_line[wp] <= bus.icache_l2_addr[31:6];
      f_data[wp] <= bus.icache_l2_data_out;
      f_state[wp] <= bus.icache_l2_state;
    end
  // queue pointers, occupancy and the illegal-op pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      bus.err_illegal <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      bus.err_illegal <= bus.icache_l2_op >= 3'd5;
    end
  // service FSM: one request in flight, memory request and response outputs registered
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      w_op <= '0;
      w_line <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_we <= 1'b0;
      bus.mem_req_addr <= '0;
      bus.mem_req_data <= '0;
      bus.l2_icache_op <= '0;
      bus.l2_icache_addr <= '0;
      bus.l2_icache_data <= '0;
      bus.l2_icache_state <= '0;
    end else
      case (st)
        IDLE:
          if (pop) begin
            w_op <= f_op[rp];
            w_line <= f_line[rp];
            if (f_op[rp] == 3'd4) begin
              st <= RESP;
              bus.l2_icache_op <= 3'd4;
              bus.l2_icache_addr <= {f_line[rp], 6'b0};
            end else begin
              st <= MEM_REQ;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_we <= f_op[rp] == 3'd2;
              bus.mem_req_addr <= {f_line[rp], 6'b0};
              bus.mem_req_data <= f_data[rp];
            end
          end
        MEM_REQ:
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_we <= 1'b0;
            bus.mem_req_addr <= '0;
            bus.mem_req_data <= '0;
            st <= w_op == 3'd2 ? RESP : MEM_WAIT;
            bus.l2_icache_op <= w_op == 3'd2 ? 3'd2 : 3'd0;
            bus.l2_icache_addr <= w_op == 3'd2 ? {w_line, 6'b0} : 32'd0;
          end
        MEM_WAIT:
          if (bus.mem_resp_valid) begin
            st <= RESP;
            bus.l2_icache_op <= 3'd5;
            bus.l2_icache_addr <= {w_line, 6'b0};
            bus.l2_icache_data <= bus.mem_resp_data;
            bus.l2_icache_state <= w_op == 3'd3 ? 3'd2 : 3'd1;
          end
        default: begin
          st <= IDLE;
          bus.l2_icache_op <= '0;
          bus.l2_icache_addr <= '0;
          bus.l2_icache_data <= '0;
          bus.l2_icache_state <= '0;
        end
      endcase
endmodule

// File: tb/tb_l2_icache_resp.sv
// tb_l2_icache_resp: randomized and directed checks of l2_icache_resp against a transaction-level model
module tb_l2_icache_resp;
  localparam int D = 4;
  typedef struct {logic [2:0] op; logic [25:0] line; logic [511:0] data;} req_t;
  logic clk = 0;
  logic rst = 1;
  int vec = 0, bad = 0, cyc = 0;
  l2_icache_resp_if bus();
  l2_icache_resp #(.FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  req_t q[$];
  req_t r;
  logic [37:0] lg[$];
  int lc[$];
  int pending = 0, rsp_n = 0, err_n = 0, rsp_cyc = 0;
  logic [2:0] rsp_op, rsp_state, eop, est;
  logic [31:0] rsp_addr, pa;
  logic [511:0] rsp_data, pd, edata;
  logic acc_prev = 0, err_exp = 0, pv = 0, pr = 0;
  int ready_pct = 100, dmin = 0, dmax = 0;
  logic spur = 0, hold = 0, kick = 0;
  function automatic logic [511:0] memline(input logic [31:0] a);
    return {16{a ^ 32'hA5A5_A5A5}};
  endfunction
  task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // model and compare: what is queued, what must be on the memory port and response bus this cycle
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      pending = 0;
      acc_prev = 0;
      err_exp = 0;
      pv = 0;
      pr = 0;
      chk("rst_stall", 512'(bus.l2_icache_stall), 512'(0));
      chk("rst_op", 512'(bus.l2_icache_op), 512'(0));
      chk("rst_req_valid", 512'(bus.mem_req_valid), 512'(0));
      chk("rst_err", 512'(bus.err_illegal), 512'(0));
    end else begin
      chk("err_illegal", 512'(bus.err_illegal), 512'(err_exp));
      if (bus.err_illegal) err_n++;
      pending += int'(acc_prev);
      if (bus.mem_req_valid && !pv) pending--;
      if (bus.l2_icache_op == 3'd4) pending--;
      chk("stall", 512'(bus.l2_icache_stall), 512'(pending == D));
      if (pv && !pr) begin
        chk("hold_valid", 512'(bus.mem_req_valid), 512'(1));
        chk("hold_addr", 512'(bus.mem_req_addr), 512'(pa));
        chk("hold_data", bus.mem_req_data, pd);
      end
      if (bus.mem_req_valid) begin
        if (q.size() == 0) chk("req_unexpected", 512'(bus.mem_req_valid), 512'(0));
        else begin
          chk("req_addr", 512'(bus.mem_req_addr), 512'({q[0].line, 6'b0}));
          chk("req_we", 512'(bus.mem_req_we), 512'(q[0].op == 3'd2));
          if (q[0].op == 3'd2) chk("req_data", bus.mem_req_data, q[0].data);
        end
      end
      if (bus.l2_icache_op != 3'd0) begin
        rsp_n++;
        rsp_cyc = cyc;
        rsp_op = bus.l2_icache_op;
        rsp_addr = bus.l2_icache_addr;
        rsp_data = bus.l2_icache_data;
        rsp_state = bus.l2_icache_state;
        lg.push_back({rsp_op, rsp_addr, rsp_state});
        lc.push_back(cyc);
        if (q.size() == 0) chk("rsp_unexpected", 512'(bus.l2_icache_op), 512'(0));
        else begin
          r = q.pop_front();
          eop = r.op == 3'd2 ? 3'd2 : r.op == 3'd4 ? 3'd4 : 3'd5;
          est = r.op == 3'd1 ? 3'd1 : r.op == 3'd3 ? 3'd2 : 3'd0;
          edata = (r.op == 3'd1 || r.op == 3'd3) ? memline({r.line, 6'b0}) : '0;
          chk("rsp_op", 512'(rsp_op), 512'(eop));
          chk("rsp_addr", 512'(rsp_addr), 512'({r.line, 6'b0}));
          chk("rsp_data", rsp_data, edata);
          chk("rsp_state", 512'(rsp_state), 512'(est));
        end
      end else begin
        chk("idle_addr", 512'(bus.l2_icache_addr), 512'(0));
        chk("idle_data", bus.l2_icache_data, 512'(0));
        chk("idle_state", 512'(bus.l2_icache_state), 512'(0));
      end
      pv = bus.mem_req_valid;
      pr = bus.mem_req_ready;
      pa = bus.mem_req_addr;
      pd = bus.mem_req_data;
      acc_prev = bus.icache_l2_op != 3'd0 && bus.icache_l2_op < 3'd5 && !bus.l2_icache_stall;
      if (acc_prev) q.push_back('{bus.icache_l2_op, bus.icache_l2_addr[31:6], bus.icache_l2_data_out});
      err_exp = bus.icache_l2_op >= 3'd5;
    end
  end
  // memory responder: random ready, read data after a bounded delay, optional stray pulses
  initial begin
    logic hs;
    logic [31:0] ra;
    int w;
    w = -1;
    ra = '0;
    bus.mem_req_ready = 0;
    bus.mem_resp_valid = 0;
    bus.mem_resp_data = '0;
    forever begin
      @(negedge clk);
      hs = bus.mem_req_valid && bus.mem_req_ready && !bus.mem_req_we && rst;
      if (hs) ra = bus.mem_req_addr;
      @(posedge clk);
      #1;
      bus.mem_resp_valid = 0;
      if (!rst) begin
        w = -1;
        hs = 0;
      end
      if (hs) w = int'($urandom_range(dmax, dmin));
      if (kick) begin
        kick = 0;
        bus.mem_resp_valid = 1;
        bus.mem_resp_data = {16{$urandom}};
      end else if (w == 0 && !hold) begin
        bus.mem_resp_valid = 1;
        bus.mem_resp_data = memline(ra);
        w = -1;
      end else if (w > 0 && !hold) w--;
      else if (w < 0 && spur && $urandom_range(7, 0) == 0) begin
        bus.mem_resp_valid = 1;
        bus.mem_resp_data = {16{$urandom}};
      end
      bus.mem_req_ready = int'($urandom_range(100, 1)) <= ready_pct;
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [511:0] d, output int e0);
    bus.icache_l2_op = op;
    bus.icache_l2_addr = a;
    bus.icache_l2_data_out = d;
    bus.icache_l2_state = 3'($urandom);
    e0 = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.l2_icache_stall || op >= 3'd5) begin
        e0 = cyc + 1;
        break;
      end
    end
    if (e0 < 0) chk("send_timeout", 512'(bus.l2_icache_stall), 512'(0));
    @(posedge clk);
    #1;
    bus.icache_l2_op = 3'd0;
  endtask
  task automatic wait_rsp(input int n0);
    for (int i = 0; i < 300 && rsp_n <= n0; i++) begin
      @(negedge clk);
      #1;
    end
    if (rsp_n <= n0) chk("rsp_timeout", 512'(rsp_n), 512'(n0 + 1));
    @(posedge clk);
    #1;
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors", vec);
    $fatal(1, "watchdog");
  end
  initial begin
    int e0, n0, e, rr;
    logic [2:0] op;
    logic [37:0] ex [6];
    ex = '{{3'd5, 32'h100, 3'd2}, {3'd4, 32'h200, 3'd0}, {3'd2, 32'h300, 3'd0},
           {3'd5, 32'h400, 3'd1}, {3'd5, 32'h500, 3'd1}, {3'd4, 32'h600, 3'd0}};
    bus.icache_l2_op = 0;
    bus.icache_l2_addr = 0;
    bus.icache_l2_data_out = 0;
    bus.icache_l2_state = 0;
    #2 rst = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    idle(2);
    dmin = 1;
    dmax = 1;
    n0 = rsp_n;
    send(3'd1, 32'h8000_107C, {16{32'h1234_5678}}, e0);
    wait_rsp(n0);
    chk("rd_lat", 512'(rsp_cyc), 512'(e0 + 4));
    chk("rd_op", 512'(rsp_op), 512'(5));
    chk("rd_addr", 512'(rsp_addr), 512'(32'h8000_1040));
    chk("rd_data", rsp_data, {16{32'h25A5_B5E5}});
    chk("rd_state", 512'(rsp_state), 512'(1));
    n0 = rsp_n;
    send(3'd4, 32'h0000_0240, '0, e0);
    wait_rsp(n0);
    chk("fl_lat", 512'(rsp_cyc), 512'(e0 + 1));
    chk("fl_addr", 512'(rsp_addr), 512'(32'h240));
    n0 = rsp_n;
    send(3'd2, 32'h0000_0380, {16{32'hDEAD_BEEF}}, e0);
    wait_rsp(n0);
    chk("w_lat", 512'(rsp_cyc), 512'(e0 + 2));
    chk("w_op", 512'(rsp_op), 512'(2));
    dmin = 0;
    dmax = 0;
    ready_pct = 0;
    n0 = rsp_n;
    send(3'd1, 32'h0000_0400, '0, e0);
    repeat (4) @(negedge clk);
    ready_pct = 100;
    wait_rsp(n0);
    chk("bp_lat", 512'(rsp_cyc), 512'(e0 + 6));
    ready_pct = 0;
    dmax = 2;
    n0 = rsp_n;
    send(3'd3, 32'h100, '0, e0);
    send(3'd4, 32'h200, '0, e0);
    send(3'd2, 32'h300, {16{32'hC0DE_0300}}, e0);
    send(3'd1, 32'h400, '0, e0);
    send(3'd1, 32'h500, '0, e0);
    @(negedge clk);
    #1;
    chk("full_stall", 512'(bus.l2_icache_stall), 512'(1));
    chk("full_req_addr", 512'(bus.mem_req_addr), 512'(32'h100));
    @(posedge clk);
    #1;
    ready_pct = 100;
    send(3'd4, 32'h600, '0, e0);
    @(negedge clk);
    #1;
    chk("pp_stall", 512'(bus.l2_icache_stall), 512'(1));
    for (int i = 0; i < 300 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("pp_accept_cyc", 512'(lc.size() > n0 + 1 ? lc[n0 + 1] : 0), 512'(e0 - 1));
    for (int i = 0; i < 6; i++) chk("order", 512'(lg.size() > n0 + i ? lg[n0 + i] : 38'd0), 512'(ex[i]));
    @(posedge clk);
    #1;
    n0 = rsp_n;
    e = err_n;
    send(3'd6, 32'h40, '0, e0);
    idle(3);
    chk("ill_err", 512'(err_n), 512'(e + 1));
    chk("ill_no_rsp", 512'(rsp_n), 512'(n0));
    chk("ill_stall", 512'(bus.l2_icache_stall), 512'(0));
    hold = 1;
    n0 = rsp_n;
    send(3'd1, 32'h0000_1040, '0, e0);
    repeat (3) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("mr_op", 512'(bus.l2_icache_op), 512'(0));
    chk("mr_valid", 512'(bus.mem_req_valid), 512'(0));
    chk("mr_addr", 512'(bus.mem_req_addr), 512'(0));
    chk("mr_stall", 512'(bus.l2_icache_stall), 512'(0));
    @(posedge clk);
    #1;
    idle(1);
    rst = 1;
    hold = 0;
    @(negedge clk);
    kick = 1;
    idle(10);
    chk("mr_no_rsp", 512'(rsp_n), 512'(n0));
    n0 = rsp_n;
    send(3'd4, 32'h0000_0A00, '0, e0);
    wait_rsp(n0);
    chk("mr_empty_lat", 512'(rsp_cyc), 512'(e0 + 1));
    ready_pct = 70;
    dmin = 0;
    dmax = 3;
    spur = 1;
    for (int i = 0; i < 500; i++) begin
      rr = int'($urandom_range(19, 0));
      op = rr < 2 ? 3'd0 : rr < 3 ? 3'(5 + $urandom_range(2, 0)) : 3'(1 + $urandom_range(3, 0));
      if (op == 3'd0) idle(int'($urandom_range(3, 1)));
      else send(op, $urandom, {16{$urandom}}, e0);
    end
    for (int i = 0; i < 2000 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", 512'(q.size()), 512'(0));
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
